// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter feeding a shared logic unit with a one-entry output register
module logic_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [2*N_REQ-1:0]         req_op,
  input  logic [WIDTH*N_REQ-1:0]     req_a,
  input  logic [WIDTH*N_REQ-1:0]     req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_data
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gidx;
  logic             found;
  logic             fire;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  // first valid requester at or after ptr, wrapping modulo N_REQ
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = IW'(idx);
      end
    end
  end
  // grant only when the slot is free (empty or draining this cycle) and reset is released
  always_comb begin
    fire      = rstn && found && (!rsp_valid || rsp_ready);
    req_ready = fire ? (N_REQ'(1) << gidx) : '0;
  end
  // shared logic unit on the winner's operands
  always_comb begin
    op     = req_op[2*gidx +: 2];
    a      = req_a[WIDTH*gidx +: WIDTH];
    b      = req_b[WIDTH*gidx +: WIDTH];
    result = op == 2'b00 ? ~a :
             op == 2'b01 ? a & b :
             op == 2'b10 ? a | b : a ^ b;
  end
  // output slot and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (fire) begin
      ptr       <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + IW'(1);
      rsp_valid <= 1'b1;
      rsp_id    <= gidx;
      rsp_data  <= result;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed stimulus checked against a queue-based reference model
module tb_logic_unit_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0;
  logic [W*N-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  int checks = 0;
  int failures = 0;

  logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {int id; logic [W-1:0] data;} rsp_t;
  rsp_t exp_q[$];
  int   m_ptr = 0;

  function automatic logic [W-1:0] lu(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    case (o)
      2'd0: return ~x;
      2'd1: return x & y;
      2'd2: return x | y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, ex);
    end
  endtask

  // reference model: response queue plus modular round-robin search
  always @(negedge clk) begin
    int g;
    #2;
    chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      chk("m_rsp_id", {30'd0, rsp_id}, exp_q[0].id);
      chk("m_rsp_data", rsp_data, exp_q[0].data);
    end
    g = -1;
    if (rstn && (exp_q.size() == 0 || rsp_ready))
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    chk("m_req_ready", {28'd0, req_ready}, g >= 0 ? (32'd1 << g) : 32'd0);
    if (!rstn) begin
      exp_q.delete();
      m_ptr = 0;
    end else begin
      if (exp_q.size() > 0 && rsp_ready) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back('{g, lu(req_op[2*g +: 2], req_a[W*g +: W], req_b[W*g +: W])});
        m_ptr = (g + 1) % N;
      end
    end
  end

  task automatic set_req(int i, logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    req_op[2*i +: 2] = o;
    req_a[W*i +: W]  = x;
    req_b[W*i +: W]  = y;
  endtask

  task automatic drv(logic rn, logic [N-1:0] v, logic rr);
    rstn = rn;
    req_valid = v;
    rsp_ready = rr;
    #3;
  endtask

  logic [N-1:0] pats [16] = '{4'b0000, 4'b0101, 4'b1111, 4'b0010, 4'b1100, 4'b1000, 4'b0111, 4'b0001,
                              4'b1010, 4'b0110, 4'b1111, 4'b0011, 4'b1001, 4'b0100, 4'b1110, 4'b1011};

  initial begin
    @(negedge clk); drv(0, 4'b1111, 1);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk); drv(0, 4'b1111, 1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk); set_req(0, 2'b00, 32'h0000FFFF, 32'h12345678); drv(1, 4'b0001, 1);
    chk("not_grant", {28'd0, req_ready}, 32'h1);
    @(negedge clk); drv(1, 4'b0000, 1);
    chk("not_valid", {31'd0, rsp_valid}, 32'd1);
    chk("not_id", {30'd0, rsp_id}, 32'd0);
    chk("not_data", rsp_data, 32'hFFFF0000);
    @(negedge clk); drv(1, 4'b0000, 1);
    chk("drain_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    set_req(1, 2'b01, 32'hF0F0F0F0, 32'h3C3C3C3C);
    set_req(3, 2'b10, 32'hF0F0F0F0, 32'h3C3C3C3C);
    drv(1, 4'b0010, 1);
    chk("and_grant", {28'd0, req_ready}, 32'h2);
    @(negedge clk); drv(1, 4'b1000, 1);
    chk("or_grant", {28'd0, req_ready}, 32'h8);
    chk("and_data", rsp_data, 32'h30303030);
    @(negedge clk); drv(1, 4'b0000, 1);
    chk("or_id", {30'd0, rsp_id}, 32'd3);
    chk("or_data", rsp_data, 32'hFCFCFCFC);
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 2'(i), 32'h11111111 * (i + 1), 32'h0F0F0F0F);
    drv(1, 4'b1111, 1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(negedge clk); drv(1, 4'b1111, 1); end
      chk("rr_grant", {28'd0, req_ready}, 32'd1 << (k % 4));
      if (k > 0) chk("rr_id", {30'd0, rsp_id}, (k - 1) % 4);
    end
    @(negedge clk); drv(1, 4'b0000, 1);
    chk("rr_last_id", {30'd0, rsp_id}, 32'd3);
    @(negedge clk); set_req(2, 2'b11, 32'hA5A5A5A5, 32'hFFFF0000); drv(1, 4'b0100, 1);
    chk("xor_grant", {28'd0, req_ready}, 32'h4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drv(1, 4'b0101, 0);
      chk("stall_ready", {28'd0, req_ready}, 32'd0);
      chk("stall_data", rsp_data, 32'h5A5AA5A5);
    end
    @(negedge clk); drv(1, 4'b0100, 1);
    chk("unstall_grant", {28'd0, req_ready}, 32'h4);
    @(negedge clk); drv(1, 4'b0000, 1);
    @(negedge clk); drv(1, 4'b1001, 1);
    chk("wrap_g3", {28'd0, req_ready}, 32'h8);
    @(negedge clk); drv(1, 4'b1001, 1);
    chk("wrap_g0", {28'd0, req_ready}, 32'h1);
    @(negedge clk); drv(1, 4'b0011, 1);
    chk("wrap_g1", {28'd0, req_ready}, 32'h2);
    @(negedge clk); drv(1, 4'b0000, 1);
    @(negedge clk); drv(1, 4'b0001, 0);
    chk("pend_grant", {28'd0, req_ready}, 32'h1);
    @(negedge clk); drv(1, 4'b0000, 0);
    chk("pend_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk); drv(0, 4'b0110, 0);
    chk("midrst_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk); drv(1, 4'b0110, 1);
    chk("postrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("postrst_grant", {28'd0, req_ready}, 32'h2);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      set_req(k % N, 2'(k), 32'h9E3779B9 * (k + 1), 32'h7F4A7C15 ^ k);
      drv(1, pats[k % 16], (k % 3) != 0);
    end
    @(negedge clk); drv(1, 4'b0000, 1);
    @(negedge clk); drv(1, 4'b0000, 1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
